// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; the producers and the Transmitter model drive the master side.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int SIZE_DATA = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*SIZE_DATA-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         tx_start;
   logic [SIZE_DATA-1:0]         tx_data;
   logic                         tx_done;
   logic                         busy;
   logic [ID_W-1:0]              grant_id;
   logic                         timeout;

   modport slave (
      input  req_valid, req_data, tx_done,
      output req_ready, tx_start, tx_data, busy, grant_id, timeout
   );

   modport master (
      output req_valid, req_data, tx_done,
      input  req_ready, tx_start, tx_data, busy, grant_id, timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Transmitter among NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to abort a grant whose frame never completes within TIMEOUT i_stick ticks.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int SIZE_DATA = 8,
   parameter int TIMEOUT   = 200
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stick,
   uart_tx_arbiter_if.slave  bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [SIZE_DATA-1:0] data_q, data_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;

   logic                 win_found;
   logic [ID_W-1:0]      win_id;
   logic [ID_W-1:0]      cand_id;
   int                   cand;
   logic [SIZE_DATA-1:0] win_data;
   logic                 expire;

   // First requesting index at or above the pointer, wrapping past NUM_REQ-1.
   // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = 0;
      cand_id   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_id = ID_W'(cand);
         if (!win_found && bus.req_valid[cand_id]) begin
            win_found = 1'b1;
            win_id    = cand_id;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) win_data = bus.req_data[i*SIZE_DATA +: SIZE_DATA];
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] tick_cnt_q;

   // Cleared whenever not in WAIT, so every frame starts its budget from zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                   tick_cnt_q <= '0;
      else if (state_q != ST_WAIT) tick_cnt_q <= '0;
      else if (i_stick)            tick_cnt_q <= tick_cnt_q + 1'b1;
   end

   // Terminal count: the TIMEOUT-th tick is being sampled at this edge.
   assign expire = (state_q == ST_WAIT) && i_stick && (tick_cnt_q == CNT_W'(TIMEOUT - 1));
`else
   localparam int unused_timeout = TIMEOUT;
   logic unused_stick;

   assign unused_stick = i_stick;
   assign expire       = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      ready_d   = '0;
      start_d   = 1'b0;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               ready_d[win_id] = 1'b1;
               grant_d         = win_id;
               data_d          = win_data;
               busy_d          = 1'b1;
               ptr_d           = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
               state_d         = ST_START;
            end
         end
         ST_START: begin
            start_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Done outranks a coincident terminal count.
            if (bus.tx_done) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (expire) begin
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         data_q    <= '0;
         ready_q   <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.tx_start  = start_q;
   assign bus.tx_data   = data_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = grant_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single grants, scoreboard of expected grants, hand-written corner sequences.
// The timeout sequences run only when UART_ARB_TIMEOUT_EN is defined (TIMEOUT=20 then).
module tb_uart_tx_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int SIZE_DATA = 8;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO = 20;
`else
   localparam int TO = 200;
`endif
   // Modelled frame length; shortened under the timeout build so normal frames never expire.
   localparam int FRAME_TICKS = (TO > 160) ? 160 : TO / 2;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [1:0]  exp_id;
      logic [7:0]  exp_byte;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stick;
   logic stick_gen  = 1'b0;
   logic stick_man  = 1'b0;
   logic stick_auto = 1'b0;
   logic done_man   = 1'b0;
   logic done_auto  = 1'b0;

   int   n_vec   = 0;
   int   n_err   = 0;
   int   n_start = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[10];

   int   m_cnt    = 0;
   bit   m_active = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE_DATA(SIZE_DATA)) bus ();

   assign stick       = stick_auto ? stick_gen : stick_man;
   assign bus.tx_done = done_man | done_auto;

   uart_tx_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .SIZE_DATA(SIZE_DATA),
      .TIMEOUT  (TO)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_stick(stick),
      .bus    (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accept pulse must match the oldest expected grant.
   always @(negedge clk) begin
      if (bus.tx_start) n_start++;
      if (bus.req_ready != 4'b0000) begin
         check("sb_grant_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("sb_ready_onehot", 32'(bus.req_ready), 32'(4'b0001 << mon_e.id));
            check("sb_grant_id", 32'(bus.grant_id), 32'(mon_e.id));
            check("sb_tx_data", 32'(bus.tx_data), 32'(mon_e.data));
            check("sb_busy", 32'(bus.busy), 32'd1);
         end
      end
   end

   // Tick source and Transmitter model: done FRAME_TICKS ticks after each start.
   always @(posedge clk) begin
      #1 stick_gen = stick_auto ? ~stick_gen : 1'b0;
   end

   always @(negedge clk) begin
      done_auto = 1'b0;
      if (!stick_auto) begin
         m_active = 1'b0;
      end else if (bus.tx_start) begin
         m_active = 1'b1;
         m_cnt    = 0;
      end else if (m_active && stick) begin
         m_cnt++;
         if (m_cnt == FRAME_TICKS) begin
            done_auto = 1'b1;
            m_active  = 1'b0;
         end
      end
   end

   // which: 0 = any accept, 1 = tx_start, 2 = busy low, 3 = timeout
   task automatic wait_for(input string name, input int which, input int limit, output int cycles);
      bit hit;
      hit    = 1'b0;
      cycles = 0;
      while (!hit && cycles < limit) begin
         @(negedge clk);
         cycles++;
         case (which)
            0:       hit = (bus.req_ready != 4'b0000);
            1:       hit = bus.tx_start;
            2:       hit = !bus.busy;
            default: hit = bus.timeout;
         endcase
      end
      check({name, "_seen"}, 32'(hit), 32'd1);
   endtask

   task automatic pulse_done();
      done_man = 1'b1;
      @(negedge clk);
      done_man = 1'b0;
   endtask

   task automatic grant_to_wait(input string name, input logic [3:0] valid, input logic [31:0] data,
                                input logic [1:0] id, input logic [7:0] byte_v);
      int c;
      sb_q.push_back({id, byte_v});
      bus.req_valid = valid;
      bus.req_data  = data;
      wait_for({name, "_grant"}, 0, 6, c);
      bus.req_valid = 4'b0000;
      bus.req_data  = 32'hFFFF_FFFF;
      wait_for({name, "_start"}, 1, 4, c);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      int  c;
      int  ticks;
      int  s0;
      bit  quiet;
      bit  hit;

      vecs[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5};
      vecs[1] = '{4'b1111, 32'h1312_1110, 2'd3, 8'h13};
      vecs[2] = '{4'b1111, 32'h2322_2120, 2'd0, 8'h20};
      vecs[3] = '{4'b0001, 32'h3332_3130, 2'd0, 8'h30};
      vecs[4] = '{4'b0101, 32'h4342_4140, 2'd2, 8'h42};
      vecs[5] = '{4'b0011, 32'h5352_5150, 2'd0, 8'h50};
      vecs[6] = '{4'b1000, 32'h6362_6160, 2'd3, 8'h63};
      vecs[7] = '{4'b0110, 32'h7372_7170, 2'd1, 8'h71};
      vecs[8] = '{4'b1001, 32'h8382_8180, 2'd3, 8'h83};
      vecs[9] = '{4'b0010, 32'h9392_9190, 2'd1, 8'h91};

      bus.req_valid = 4'b0000;
      bus.req_data  = 32'h0;

      // Reset values
      #1 rst = 1'b1;
      #2;
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_start", 32'(bus.tx_start), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_grant_id", 32'(bus.grant_id), 32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table of single grants, pointer carried from one vector to the next
      for (int i = 0; i < 10; i++) begin
         sb_q.push_back({vecs[i].exp_id, vecs[i].exp_byte});
         bus.req_valid = vecs[i].valid;
         bus.req_data  = vecs[i].data;
         wait_for("vec_grant", 0, 6, c);
         check("vec_grant_latency", 32'(c), 32'd1);
         bus.req_valid = 4'b0000;
         bus.req_data  = 32'hFFFF_FFFF;
         @(negedge clk);
         check("vec_start_pulse", 32'(bus.tx_start), 32'd1);
         check("vec_ready_single", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
         check("vec_start_single", 32'(bus.tx_start), 32'd0);
         check("vec_busy_wait", 32'(bus.busy), 32'd1);
         repeat (3) @(negedge clk);
         pulse_done();
         check("vec_busy_clear", 32'(bus.busy), 32'd0);
         check("vec_data_hold", 32'(bus.tx_data), 32'(vecs[i].exp_byte));
         check("vec_timeout_idle", 32'(bus.timeout), 32'd0);
      end

      // Stray done in IDLE must be ignored
      pulse_done();
      quiet = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy || bus.tx_start || (bus.req_ready != 4'b0000)) quiet = 1'b0;
      end
      check("stray_done_quiet", 32'(quiet), 32'd1);

      // Requester 3 raises and drops valid while busy: never granted
      grant_to_wait("withdraw", 4'b0001, 32'h0000_00C3, 2'd0, 8'hC3);
      @(negedge clk);
      bus.req_valid = 4'b1000;
      bus.req_data  = 32'hD400_0000;
      repeat (2) @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      pulse_done();
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.req_ready != 4'b0000) quiet = 1'b0;
      end
      check("withdrawn_no_grant", 32'(quiet), 32'd1);

      // Back-to-back: requester 1 held valid, done 5 cycles after start, next start 3 cycles after done
      sb_q.push_back({2'd1, 8'hB7});
      sb_q.push_back({2'd1, 8'hB7});
      bus.req_valid = 4'b0010;
      bus.req_data  = 32'h0000_B700;
      wait_for("b2b_grant", 0, 6, c);
      wait_for("b2b_start", 1, 4, c);
      repeat (5) @(negedge clk);
      pulse_done();
      wait_for("b2b_restart", 1, 10, c);
      check("b2b_done_to_start", 32'(c + 1), 32'd3);
      bus.req_valid = 4'b0000;
      repeat (2) @(negedge clk);
      pulse_done();
      check("b2b_busy_clear", 32'(bus.busy), 32'd0);

      // Reset in WAIT clears everything at once; pointer returns to 0
      grant_to_wait("midrst", 4'b0100, 32'h00E9_0000, 2'd2, 8'hE9);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ready", 32'(bus.req_ready), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
      check("midrst_grant_id", 32'(bus.grant_id), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Round robin with all four requesting and the Transmitter model closing frames
      stick_auto = 1'b1;
      s0 = n_start;
      sb_q.push_back({2'd0, 8'hF0});
      sb_q.push_back({2'd1, 8'hF1});
      sb_q.push_back({2'd2, 8'hF2});
      sb_q.push_back({2'd3, 8'hF3});
      sb_q.push_back({2'd0, 8'hF0});
      bus.req_valid = 4'b1111;
      bus.req_data  = 32'hF3F2_F1F0;
      for (int k = 0; k < 5; k++) wait_for("rr_grant", 0, 4 * FRAME_TICKS + 20, c);
      bus.req_valid = 4'b0000;
      wait_for("rr_final_done", 2, 4 * FRAME_TICKS + 20, c);
      check("rr_start_count", 32'(n_start - s0), 32'd5);
      check("rr_sb_drained", 32'(sb_q.size()), 32'd0);
      stick_auto = 1'b0;
      repeat (2) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
      // Withheld done: abort right after the 20th tick; pointer was 1 so requester 3 wins
      grant_to_wait("to_a", 4'b1000, 32'h5A00_0000, 2'd3, 8'h5A);
      ticks = 0;
      hit   = 1'b0;
      while (!hit && ticks < 40) begin
         stick_man = 1'b1;
         @(negedge clk);
         ticks++;
         hit = bus.timeout;
      end
      stick_man = 1'b0;
      check("to_a_seen", 32'(hit), 32'd1);
      check("to_a_tick", 32'(ticks), 32'(TO));
      check("to_a_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("to_a_single", 32'(bus.timeout), 32'd0);

      // Done on the 20th tick wins; post-grant pointer (0) kept after the abort
      grant_to_wait("to_b", 4'b1111, 32'hC7C6_C5C4, 2'd0, 8'hC4);
      quiet = 1'b1;
      for (int t = 1; t < TO; t++) begin
         stick_man = 1'b1;
         @(negedge clk);
         if (bus.timeout) quiet = 1'b0;
      end
      stick_man = 1'b1;
      done_man  = 1'b1;
      @(negedge clk);
      stick_man = 1'b0;
      done_man  = 1'b0;
      if (bus.timeout) quiet = 1'b0;
      check("to_b_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      if (bus.timeout) quiet = 1'b0;
      check("to_b_no_timeout", 32'(quiet), 32'd1);
`endif

      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
